rca_use_exec_unit: RTL and testbench

Parametrised successor to the stub RCA execution unit. It accepts RCA issue requests and completes config instructions with a zero result. For use instructions it holds the source operands until the PR grid accepts them, and tracks up to MAX_INFLIGHT outstanding ops in order. It gathers per-write-port grid results, pops the grid IO FIFOs, and drives a registered writeback with a stall-safe ack handshake and a per-op timeout.

---
 rtl/rca_use_exec_unit.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rca_use_exec_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_use_exec_unit.sv
// rca_use_exec_unit
// Execution unit for RCA issue requests.
// - Config instructions complete with a zero writeback.
// - Use instructions do three things:
//   - park their operands in a skid register until the PR grid accepts them;
//   - record {id, wr_mask} in an in-order tracking FIFO;
//   - retire when the grid IO units show every masked result port valid,
//     or when the head op waits too long (timeout).
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   issue_*                 issue handshake and payload (issue_ready out)
//   flush                   drop pending config, skid operands and tracked ops
//   grid_inp_* / grid_rs    operand handoff to the PR grid
//   result_valid/data/pop   per-write-port grid outputs and their pop strobes
//   wb_*                    registered writeback, held until wb_ack
//   inflight_count          number of tracked use ops
module rca_use_exec_unit #(
  parameter int XLEN            = 32,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 5,
  parameter int NUM_RCAS        = 4,
  parameter int ID_W            = 3,
  parameter int MAX_INFLIGHT    = 4,
  parameter int TIMEOUT_CYCLES  = 256,
  localparam int SEL_W          = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int CNT_W          = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue_new_request,
  output logic                              issue_ready,
  input  logic [ID_W-1:0]                   issue_id,
  input  logic                              issue_use_instr,
  input  logic [SEL_W-1:0]                  issue_rca_sel,
  input  logic [NUM_WRITE_PORTS-1:0]        issue_wr_mask,
  input  logic [NUM_READ_PORTS*XLEN-1:0]    issue_rs,
  input  logic                              flush,
  output logic                              grid_inp_valid,
  input  logic                              grid_inp_ready,
  output logic [SEL_W-1:0]                  grid_rca_sel,
  output logic [NUM_READ_PORTS*XLEN-1:0]    grid_rs,
  input  logic [NUM_WRITE_PORTS-1:0]        result_valid,
  input  logic [NUM_WRITE_PORTS*XLEN-1:0]   result_data,
  output logic [NUM_WRITE_PORTS-1:0]        result_pop,
  output logic                              wb_done,
  output logic [ID_W-1:0]                   wb_id,
  output logic [NUM_WRITE_PORTS*XLEN-1:0]   wb_rd,
  output logic [NUM_WRITE_PORTS-1:0]        wb_rd_mask,
  output logic                              wb_timeout,
  input  logic                              wb_ack,
  output logic [CNT_W-1:0]                  inflight_count
);

  localparam int PTR_W      = $clog2(MAX_INFLIGHT);
  localparam int TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LAST_I);
  localparam bit   TMO_EN   = (TIMEOUT_CYCLES > 0);

  // Operand skid register
  logic                           skid_full_q, skid_full_d;
  logic [SEL_W-1:0]               skid_rca_q, skid_rca_d;
  logic [NUM_READ_PORTS*XLEN-1:0] skid_rs_q, skid_rs_d;
  // In-order tracking FIFO; pointers carry an extra wrap bit
  logic [ID_W-1:0]                fifo_id_q   [MAX_INFLIGHT];
  logic [NUM_WRITE_PORTS-1:0]     fifo_mask_q [MAX_INFLIGHT];
  logic [CNT_W-1:0]               wr_ptr_q, rd_ptr_q;
  // Pending config completion and head timeout counter
  logic                           cfg_pending_q, cfg_pending_d;
  logic [ID_W-1:0]                cfg_id_q, cfg_id_d;
  logic [TMO_W-1:0]               tmo_cnt_q, tmo_cnt_d;
  // Writeback register
  logic                           wb_done_q, wb_done_d;
  logic [ID_W-1:0]                wb_id_q, wb_id_d;
  logic [NUM_WRITE_PORTS*XLEN-1:0] wb_rd_q, wb_rd_d;
  logic [NUM_WRITE_PORTS-1:0]     wb_mask_q, wb_mask_d;
  logic                           wb_tmo_q, wb_tmo_d;

  logic                           fifo_empty_s, head_done_s, tmo_fire_s;
  logic [CNT_W-1:0]               inflight_s;
  logic [ID_W-1:0]                head_id_s, cfg_id_s;
  logic [NUM_WRITE_PORTS-1:0]     head_mask_s, pop_mask_s;
  logic [NUM_WRITE_PORTS*XLEN-1:0] wb_data_s;
  logic issue_fire_s, use_push_s, cfg_issue_s, wb_free_s;
  logic load_use_s, load_tmo_s, load_cfg_s, head_pop_s;

  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign inflight_s   = wr_ptr_q - rd_ptr_q;
  assign head_id_s    = fifo_id_q[rd_ptr_q[PTR_W-1:0]];
  assign head_mask_s  = fifo_mask_q[rd_ptr_q[PTR_W-1:0]];
  // A zero mask satisfies the equality immediately, so such ops retire at head.
  assign head_done_s  = !fifo_empty_s && ((result_valid & head_mask_s) == head_mask_s);
  assign tmo_fire_s   = TMO_EN && !fifo_empty_s && !head_done_s && (tmo_cnt_q == TMO_LAST);

  assign issue_ready  = !rst && !flush && !skid_full_q && !cfg_pending_q &&
                        (inflight_s < CNT_W'(MAX_INFLIGHT));
  assign issue_fire_s = issue_new_request && issue_ready;
  assign use_push_s   = issue_fire_s && issue_use_instr;
  assign cfg_issue_s  = issue_fire_s && !issue_use_instr;

  // The writeback slot frees up in the same cycle it is acknowledged (no bubble).
  assign wb_free_s    = !wb_done_q || wb_ack;
  assign load_use_s   = !flush && wb_free_s && head_done_s;
  assign load_tmo_s   = !flush && wb_free_s && tmo_fire_s;
  // A config issued this cycle bypasses cfg_pending when the slot is free.
  assign load_cfg_s   = !flush && wb_free_s && (cfg_pending_q || cfg_issue_s) &&
                        !load_use_s && !load_tmo_s;
  assign head_pop_s   = load_use_s || load_tmo_s;
  assign cfg_id_s     = cfg_pending_q ? cfg_id_q : issue_id;

  // Ports delivered by the head this cycle, and the gated writeback data
  always_comb begin
    pop_mask_s = '0;
    wb_data_s  = '0;
    if (load_use_s) begin
      pop_mask_s = head_mask_s;
    end else if (load_tmo_s) begin
      pop_mask_s = head_mask_s & result_valid;
    end else begin
      pop_mask_s = '0;
    end
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      if (pop_mask_s[p]) begin
        wb_data_s[p*XLEN +: XLEN] = result_data[p*XLEN +: XLEN];
      end else begin
        wb_data_s[p*XLEN +: XLEN] = '0;
      end
    end
  end

  // Next state: skid register, config pending, timeout counter, writeback
  always_comb begin
    skid_full_d   = skid_full_q;
    skid_rca_d    = skid_rca_q;
    skid_rs_d     = skid_rs_q;
    cfg_pending_d = cfg_pending_q;
    cfg_id_d      = cfg_id_q;
    tmo_cnt_d     = tmo_cnt_q;
    wb_done_d     = wb_done_q;
    wb_id_d       = wb_id_q;
    wb_rd_d       = wb_rd_q;
    wb_mask_d     = wb_mask_q;
    wb_tmo_d      = wb_tmo_q;

    if (flush) begin
      skid_full_d = 1'b0;
    end else if (use_push_s) begin
      skid_full_d = 1'b1;
      skid_rca_d  = issue_rca_sel;
      skid_rs_d   = issue_rs;
    end else if (skid_full_q && grid_inp_ready) begin
      skid_full_d = 1'b0;
    end else begin
      skid_full_d = skid_full_q;
    end

    if (flush || load_cfg_s) begin
      cfg_pending_d = 1'b0;
    end else if (cfg_issue_s) begin
      cfg_pending_d = 1'b1;
      cfg_id_d      = issue_id;
    end else begin
      cfg_pending_d = cfg_pending_q;
    end

    // Counts only while the head is incomplete; it saturates at the fire value
    // so a timed-out head that finds the writeback busy fires as soon as it frees.
    if (flush || head_pop_s || fifo_empty_s) begin
      tmo_cnt_d = '0;
    end else if (TMO_EN && !head_done_s && (tmo_cnt_q != TMO_LAST)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end

    if (head_pop_s) begin
      wb_done_d = 1'b1;
      wb_id_d   = head_id_s;
      wb_rd_d   = wb_data_s;
      wb_mask_d = pop_mask_s;
      wb_tmo_d  = load_tmo_s;
    end else if (load_cfg_s) begin
      wb_done_d = 1'b1;
      wb_id_d   = cfg_id_s;
      wb_rd_d   = '0;
      wb_mask_d = '0;
      wb_tmo_d  = 1'b0;
    end else if (wb_ack) begin
      wb_done_d = 1'b0;
      wb_id_d   = '0;
      wb_rd_d   = '0;
      wb_mask_d = '0;
      wb_tmo_d  = 1'b0;
    end else begin
      wb_done_d = wb_done_q;
    end
  end

  // State registers for skid, config, timeout and writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_full_q   <= 1'b0;
      skid_rca_q    <= '0;
      skid_rs_q     <= '0;
      cfg_pending_q <= 1'b0;
      cfg_id_q      <= '0;
      tmo_cnt_q     <= '0;
      wb_done_q     <= 1'b0;
      wb_id_q       <= '0;
      wb_rd_q       <= '0;
      wb_mask_q     <= '0;
      wb_tmo_q      <= 1'b0;
    end else begin
      skid_full_q   <= skid_full_d;
      skid_rca_q    <= skid_rca_d;
      skid_rs_q     <= skid_rs_d;
      cfg_pending_q <= cfg_pending_d;
      cfg_id_q      <= cfg_id_d;
      tmo_cnt_q     <= tmo_cnt_d;
      wb_done_q     <= wb_done_d;
      wb_id_q       <= wb_id_d;
      wb_rd_q       <= wb_rd_d;
      wb_mask_q     <= wb_mask_d;
      wb_tmo_q      <= wb_tmo_d;
    end
  end

  // Tracking FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        fifo_id_q[i]   <= '0;
        fifo_mask_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (use_push_s) begin
        fifo_id_q[wr_ptr_q[PTR_W-1:0]]   <= issue_id;
        fifo_mask_q[wr_ptr_q[PTR_W-1:0]] <= issue_wr_mask;
        wr_ptr_q <= wr_ptr_q + CNT_W'(1);
      end
      if (head_pop_s) begin
        rd_ptr_q <= rd_ptr_q + CNT_W'(1);
      end
    end
  end

  assign grid_inp_valid = skid_full_q;
  assign grid_rca_sel   = skid_rca_q;
  assign grid_rs        = skid_rs_q;
  assign result_pop     = pop_mask_s;
  assign wb_done        = wb_done_q;
  assign wb_id          = wb_id_q;
  assign wb_rd          = wb_rd_q;
  assign wb_rd_mask     = wb_mask_q;
  assign wb_timeout     = wb_tmo_q;
  assign inflight_count = inflight_s;

endmodule

// File: tb/tb_rca_use_exec_unit.sv
// Directed self-checking bench for rca_use_exec_unit (TIMEOUT_CYCLES=8).
module tb_rca_use_exec_unit;
  localparam int XLEN = 32;
  localparam int NRP  = 5;
  localparam int NWP  = 5;
  localparam int ID_W = 3;

  typedef logic [NWP*XLEN-1:0] v_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 issue_new_request;
  logic                 issue_ready;
  logic [ID_W-1:0]      issue_id;
  logic                 issue_use_instr;
  logic [1:0]           issue_rca_sel;
  logic [NWP-1:0]       issue_wr_mask;
  logic [NRP*XLEN-1:0]  issue_rs;
  logic                 flush;
  logic                 grid_inp_valid;
  logic                 grid_inp_ready;
  logic [1:0]           grid_rca_sel;
  logic [NRP*XLEN-1:0]  grid_rs;
  logic [NWP-1:0]       result_valid;
  logic [NWP*XLEN-1:0]  result_data;
  logic [NWP-1:0]       result_pop;
  logic                 wb_done;
  logic [ID_W-1:0]      wb_id;
  logic [NWP*XLEN-1:0]  wb_rd;
  logic [NWP-1:0]       wb_rd_mask;
  logic                 wb_timeout;
  logic                 wb_ack;
  logic [2:0]           inflight_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rca_use_exec_unit #(
    .XLEN(XLEN), .NUM_READ_PORTS(NRP), .NUM_WRITE_PORTS(NWP), .NUM_RCAS(4),
    .ID_W(ID_W), .MAX_INFLIGHT(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_new_request(issue_new_request), .issue_ready(issue_ready),
    .issue_id(issue_id), .issue_use_instr(issue_use_instr),
    .issue_rca_sel(issue_rca_sel), .issue_wr_mask(issue_wr_mask),
    .issue_rs(issue_rs), .flush(flush),
    .grid_inp_valid(grid_inp_valid), .grid_inp_ready(grid_inp_ready),
    .grid_rca_sel(grid_rca_sel), .grid_rs(grid_rs),
    .result_valid(result_valid), .result_data(result_data), .result_pop(result_pop),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_rd_mask(wb_rd_mask),
    .wb_timeout(wb_timeout), .wb_ack(wb_ack), .inflight_count(inflight_count)
  );

  task automatic chk(input string tag, input v_t act, input v_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, still well before the next edge.
  task automatic settle();
    #2;
  endtask

  function automatic v_t port_val(input int p, input logic [XLEN-1:0] val);
    v_t v;
    v = '0;
    v[p*XLEN +: XLEN] = val;
    return v;
  endfunction

  task automatic issue(input logic use_i, input logic [ID_W-1:0] id, input logic [NWP-1:0] mask);
    issue_new_request = 1'b1;
    issue_use_instr   = use_i;
    issue_id          = id;
    issue_wr_mask     = mask;
  endtask

  initial begin
    v_t rs1;
    rst = 1'b1; issue_new_request = 1'b0; issue_id = '0; issue_use_instr = 1'b0;
    issue_rca_sel = '0; issue_wr_mask = '0; issue_rs = '0; flush = 1'b0;
    grid_inp_ready = 1'b0; result_valid = '0; result_data = '0; wb_ack = 1'b0;
    rs1 = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};

    // Reset state
    nxt(); settle();
    chk("rst_issue_ready", v_t'(issue_ready), v_t'(1'b0));
    chk("rst_wb_done", v_t'(wb_done), v_t'(1'b0));
    chk("rst_grid_valid", v_t'(grid_inp_valid), v_t'(1'b0));
    chk("rst_inflight", v_t'(inflight_count), v_t'(3'd0));
    chk("rst_pop", v_t'(result_pop), v_t'(5'd0));

    // Config issue id=2, ack tied high
    nxt(); rst = 1'b0; issue(1'b0, 3'd2, 5'b0); wb_ack = 1'b1; settle();
    chk("cfg_ready", v_t'(issue_ready), v_t'(1'b1));
    nxt(); issue_new_request = 1'b0; settle();
    chk("cfg_done", v_t'(wb_done), v_t'(1'b1));
    chk("cfg_id", v_t'(wb_id), v_t'(3'd2));
    chk("cfg_mask", v_t'(wb_rd_mask), v_t'(5'd0));
    chk("cfg_tmo", v_t'(wb_timeout), v_t'(1'b0));
    nxt(); settle();
    chk("cfg_done_clr", v_t'(wb_done), v_t'(1'b0));
    wb_ack = 1'b0;

    // Use op id=1 with a 3-cycle grid stall
    nxt(); issue(1'b1, 3'd1, 5'b00011); issue_rca_sel = 2'd2; issue_rs = rs1; settle();
    chk("use_ready", v_t'(issue_ready), v_t'(1'b1));
    nxt(); issue_new_request = 1'b0; issue_rs = '0; settle();
    chk("use_gvalid", v_t'(grid_inp_valid), v_t'(1'b1));
    chk("use_grs", v_t'(grid_rs), rs1);
    chk("use_gsel", v_t'(grid_rca_sel), v_t'(2'd2));
    chk("use_inflight", v_t'(inflight_count), v_t'(3'd1));
    chk("use_ready_skid", v_t'(issue_ready), v_t'(1'b0));
    for (int s = 0; s < 2; s++) begin
      nxt(); settle();
      chk("stall_grs", v_t'(grid_rs), rs1);
    end
    nxt(); grid_inp_ready = 1'b1; settle();
    chk("stall_gvalid", v_t'(grid_inp_valid), v_t'(1'b1));
    nxt(); grid_inp_ready = 1'b0; result_valid = 5'b00011;
    result_data = {32'h0, 32'hC0DE, 32'hDEAD, 32'hB, 32'hA}; settle();
    chk("acc_gvalid", v_t'(grid_inp_valid), v_t'(1'b0));
    chk("use_pop", v_t'(result_pop), v_t'(5'b00011));
    nxt(); result_valid = '0; settle();
    chk("use_pop_clr", v_t'(result_pop), v_t'(5'd0));
    chk("use_wb_done", v_t'(wb_done), v_t'(1'b1));
    chk("use_wb_id", v_t'(wb_id), v_t'(3'd1));
    chk("use_wb_rd", wb_rd, v_t'({32'h0, 32'h0, 32'h0, 32'hB, 32'hA}));
    chk("use_wb_mask", v_t'(wb_rd_mask), v_t'(5'b00011));
    chk("use_wb_tmo", v_t'(wb_timeout), v_t'(1'b0));
    chk("use_inflight0", v_t'(inflight_count), v_t'(3'd0));
    wb_ack = 1'b1;
    nxt(); wb_ack = 1'b0; settle();
    chk("use_wb_clr", v_t'(wb_done), v_t'(1'b0));

    // Fill all four slots, then deliver results in order
    wb_ack = 1'b1; grid_inp_ready = 1'b1;
    for (int k = 0; k < NWP; k++) result_data[k*XLEN +: XLEN] = 32'(32'h100 + k);
    for (int k = 0; k < 4; k++) begin
      nxt(); issue(1'b1, 3'(k), 5'(5'b00001 << k)); settle();
      chk("fill_ready", v_t'(issue_ready), v_t'(1'b1));
      nxt(); issue_new_request = 1'b0;
    end
    result_valid = 5'b01110; settle();
    chk("full_inflight", v_t'(inflight_count), v_t'(3'd4));
    chk("full_ready", v_t'(issue_ready), v_t'(1'b0));
    chk("ooo_no_pop", v_t'(result_pop), v_t'(5'd0));
    for (int k = 0; k < 4; k++) begin
      nxt(); result_valid = 5'b01111; settle();
      chk("order_pop", v_t'(result_pop), v_t'(5'(5'b00001 << k)));
      if (k > 0) begin
        chk("order_done", v_t'(wb_done), v_t'(1'b1));
        chk("order_id", v_t'(wb_id), v_t'(3'(k - 1)));
        chk("order_tmo", v_t'(wb_timeout), v_t'(1'b0));
      end
    end
    nxt(); result_valid = '0; settle();
    chk("order_last_id", v_t'(wb_id), v_t'(3'd3));
    chk("order_last_rd", wb_rd, port_val(3, 32'h103));
    chk("order_last_mask", v_t'(wb_rd_mask), v_t'(5'b01000));
    chk("order_inflight0", v_t'(inflight_count), v_t'(3'd0));
    nxt(); settle();
    chk("order_done_clr", v_t'(wb_done), v_t'(1'b0));

    // Writeback held 5 cycles while the next op completes
    wb_ack = 1'b0;
    nxt(); issue(1'b1, 3'd4, 5'b00001);
    nxt(); issue_new_request = 1'b0;
    nxt(); issue(1'b1, 3'd5, 5'b00010);
    nxt(); issue_new_request = 1'b0; result_valid = 5'b00011;
    result_data = '0; result_data[31:0] = 32'h44; result_data[63:32] = 32'h55; settle();
    chk("hold_pop1", v_t'(result_pop), v_t'(5'b00001));
    for (int s = 0; s < 5; s++) begin
      nxt(); settle();
      chk("hold_done", v_t'(wb_done), v_t'(1'b1));
      chk("hold_id", v_t'(wb_id), v_t'(3'd4));
      chk("hold_rd", wb_rd, port_val(0, 32'h44));
      chk("hold_no_pop", v_t'(result_pop), v_t'(5'd0));
    end
    nxt(); wb_ack = 1'b1; settle();
    chk("ack_pop2", v_t'(result_pop), v_t'(5'b00010));
    nxt(); result_valid = '0; settle();
    chk("b2b_done", v_t'(wb_done), v_t'(1'b1));
    chk("b2b_id", v_t'(wb_id), v_t'(3'd5));
    chk("b2b_rd", wb_rd, port_val(1, 32'h55));
    nxt(); wb_ack = 1'b0; settle();
    chk("b2b_clr", v_t'(wb_done), v_t'(1'b0));

    // Timeout: mask 00111 with only port0 valid
    wb_ack = 1'b1;
    nxt(); issue(1'b1, 3'd6, 5'b00111);
    nxt(); issue_new_request = 1'b0; result_valid = 5'b00001;
    result_data = '0; result_data[31:0] = 32'h77; settle();
    chk("tmo_wait_pop", v_t'(result_pop), v_t'(5'd0));
    for (int s = 2; s < 8; s++) begin
      nxt(); settle();
      chk("tmo_wait_pop", v_t'(result_pop), v_t'(5'd0));
    end
    nxt(); settle();
    chk("tmo_pop", v_t'(result_pop), v_t'(5'b00001));
    nxt(); result_valid = '0; settle();
    chk("tmo_done", v_t'(wb_done), v_t'(1'b1));
    chk("tmo_flag", v_t'(wb_timeout), v_t'(1'b1));
    chk("tmo_id", v_t'(wb_id), v_t'(3'd6));
    chk("tmo_mask", v_t'(wb_rd_mask), v_t'(5'b00001));
    chk("tmo_rd", wb_rd, port_val(0, 32'h77));
    chk("tmo_inflight", v_t'(inflight_count), v_t'(3'd0));
    nxt(); wb_ack = 1'b0; settle();
    chk("tmo_clr", v_t'(wb_done), v_t'(1'b0));

    // Flush with a held writeback and two ops in flight
    nxt(); issue(1'b0, 3'd7, 5'b0);
    nxt(); issue(1'b1, 3'd1, 5'b00001); settle();
    chk("fl_held_id", v_t'(wb_id), v_t'(3'd7));
    nxt(); issue_new_request = 1'b0;
    nxt(); grid_inp_ready = 1'b0; issue(1'b1, 3'd2, 5'b00010);
    nxt(); issue_new_request = 1'b0; flush = 1'b1; settle();
    chk("fl_inflight2", v_t'(inflight_count), v_t'(3'd2));
    chk("fl_ready", v_t'(issue_ready), v_t'(1'b0));
    nxt(); flush = 1'b0; result_valid = 5'b11111; settle();
    chk("fl_inflight0", v_t'(inflight_count), v_t'(3'd0));
    chk("fl_gvalid", v_t'(grid_inp_valid), v_t'(1'b0));
    chk("fl_pop", v_t'(result_pop), v_t'(5'd0));
    chk("fl_wb_kept", v_t'(wb_done), v_t'(1'b1));
    chk("fl_wb_id", v_t'(wb_id), v_t'(3'd7));
    nxt(); wb_ack = 1'b1;
    nxt(); wb_ack = 1'b0; result_valid = '0;
    for (int s = 0; s < 3; s++) begin
      settle();
      chk("fl_no_more_wb", v_t'(wb_done), v_t'(1'b0));
      nxt();
    end

    // Reset while a writeback is held
    issue(1'b0, 3'd3, 5'b0);
    nxt(); issue_new_request = 1'b0; settle();
    chk("rh_done", v_t'(wb_done), v_t'(1'b1));
    rst = 1'b1; #1;
    chk("rh_ready_rst", v_t'(issue_ready), v_t'(1'b0));
    nxt(); rst = 1'b0; settle();
    chk("rh_done_clr", v_t'(wb_done), v_t'(1'b0));
    chk("rh_id_clr", v_t'(wb_id), v_t'(3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
